// File: rtl/optical_gate_bist.sv
// Built-in self-test sequencer for the optical AND/OR gate pair.
// Sweeps {A,B} through all four vectors, waits a settling time, then checks both outputs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | drives 00, waits for start
// SETTLE | current vector on the gates, counting down the settling time
// SAMPLE | one cycle: compare gate outputs, advance to the next vector
// DONE   | one cycle: done pulse, results frozen until the next start
module optical_gate_bist #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             drv_a,
    output logic             drv_b,
    input  logic             y_and,
    input  logic             y_or,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        vec;
    logic [LOOP_W-1:0] loop_idx;
    logic              y_and_q;
    logic              y_or_q;
    logic              sat;

    logic              start_run;
    logic              do_sample;
    logic              last_vec;
    logic              miss_and;
    logic              miss_or;
    logic              ovf;
    logic [1:0]        vec_inc;
    logic [1:0]        n_miss;
    logic [ERR_W:0]    err_sum;
    logic [ERR_W-1:0]  err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        start_run  = 1'b0;
        do_sample  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy       = 1'b1;
                do_sample  = 1'b1;
                state_next = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The gate outputs are not timed against our clock, so they are captured
    // once; the compare uses the value seen at the edge that entered SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_and_q <= 1'b0;
            y_or_q  <= 1'b0;
        end else begin
            y_and_q <= y_and;
            y_or_q  <= y_or;
        end
    end

    assign last_vec = (vec == 2'd3) && (loop_idx == LOOP_LAST);
    assign vec_inc  = vec + 2'd1;
    assign miss_and = y_and_q ^ (vec[1] & vec[0]);
    assign miss_or  = y_or_q ^ (vec[1] | vec[0]);
    assign n_miss   = {1'b0, miss_and} + {1'b0, miss_or};
    assign err_sum  = {1'b0, err_count} + (ERR_W + 1)'(n_miss);
    assign ovf      = err_sum[ERR_W];
    assign err_next = ovf ? ERR_MAX : err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            vec       <= 2'd0;
            loop_idx  <= '0;
            drv_a     <= 1'b0;
            drv_b     <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            if (start_run) begin
                cnt       <= CNT_LOAD;
                vec       <= 2'd0;
                loop_idx  <= '0;
                drv_a     <= 1'b0;
                drv_b     <= 1'b0;
                err_count <= '0;
                fail_vec  <= 4'd0;
                pass      <= 1'b0;
                sat       <= 1'b0;
            end
            if ((state == SETTLE) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_sample) begin
                err_count <= err_next;
                sat       <= sat | ovf;
                if (miss_and || miss_or) begin
                    fail_vec <= fail_vec | (4'd1 << vec);
                end
                // The drive change shares the sample edge; after the last
                // vector vec_inc wraps to 00, which is the idle drive.
                vec   <= vec_inc;
                drv_a <= vec_inc[1];
                drv_b <= vec_inc[0];
                cnt   <= CNT_LOAD;
                if (vec == 2'd3) begin
                    loop_idx <= loop_idx + LOOP_W'(1);
                end
                if (last_vec) begin
                    pass <= (err_next == '0) && !(sat | ovf);
                end
            end
        end
    end

endmodule

// File: tb/tb_optical_gate_bist.sv
// Bench for optical_gate_bist: four instances with different settle/loop/width
// settings, each driven by a behavioural gate-pair model with selectable faults.
module tb_optical_gate_bist;

    // gate model modes: 0 ideal, 1 AND stuck 1, 2 both inverted,
    // 3 ideal with 3-cycle delay, 4 OR stuck 0, 5 AND inverted
    typedef struct {
        int         g;
        int         mode;
        logic [7:0] err;
        logic [3:0] fail;
        logic       pass;
        int         delay;
    } row_t;

    typedef struct {
        int         g;
        logic [7:0] err;
        logic [3:0] fail;
        logic       pass;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]      rst_n_s = 4'b0000;
    logic [3:0]      start_s = 4'b0000;
    int              mode_s[4] = '{0, 0, 0, 0};
    logic [3:0][1:0] drv_w;
    logic [3:0]      busy_w;
    logic [3:0]      done_w;
    logic [3:0]      pass_w;
    logic [3:0][7:0] err_w;
    logic [3:0][3:0] fail_w;

    exp_t sb_q[$];
    row_t rows[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S = (g == 3) ? 2 : 4;
        localparam int L = (g == 1 || g == 2) ? 2 : 1;
        localparam int E = (g == 2) ? 3 : 8;

        logic         da, db, ya, yo, bz, dn, ps;
        logic [E-1:0] ec;
        logic [3:0]   fv;
        logic [1:0]   d1 = 2'b00;
        logic [1:0]   d2 = 2'b00;
        logic [1:0]   d3 = 2'b00;
        logic [1:0]   src;

        optical_gate_bist #(
            .SETTLE_CYCLES(S),
            .LOOPS(L),
            .ERR_W(E)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n_s[g]),
            .start(start_s[g]),
            .drv_a(da),
            .drv_b(db),
            .y_and(ya),
            .y_or(yo),
            .busy(bz),
            .done(dn),
            .pass(ps),
            .err_count(ec),
            .fail_vec(fv)
        );

        always @(posedge clk) begin
            d1 <= {da, db};
            d2 <= d1;
            d3 <= d2;
        end

        always_comb begin
            src = (mode_s[g] == 3) ? d3 : {da, db};
            ya  = src[1] & src[0];
            yo  = src[1] | src[0];
            case (mode_s[g])
                1: ya = 1'b1;
                2: begin
                    ya = ~ya;
                    yo = ~yo;
                end
                4: yo = 1'b0;
                5: ya = ~ya;
                default: ;
            endcase
        end

        assign drv_w[g]  = {da, db};
        assign busy_w[g] = bz;
        assign done_w[g] = dn;
        assign pass_w[g] = ps;
        assign err_w[g]  = 8'(ec);
        assign fail_w[g] = fv;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (done_w[g] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(g), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_inst", 32'(g), 32'(e.g));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("err_count", 32'(err_w[g]), 32'(e.err));
                    check("fail_vec", 32'(fail_w[g]), 32'(e.fail));
                    check("pass", 32'(pass_w[g]), 32'(e.pass));
                    check("busy_at_done", 32'(busy_w[g]), 32'd0);
                end
            end
        end
    end

    task automatic push_exp(input int g, input logic [7:0] err, input logic [3:0] fail,
                            input logic pass, input int at_cyc);
        exp_t e;
        e.g    = g;
        e.err  = err;
        e.fail = fail;
        e.pass = pass;
        e.cyc  = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic run_row(input row_t r);
        mode_s[r.g] = r.mode;
        @(negedge clk);
        start_s[r.g] = 1'b1;
        push_exp(r.g, r.err, r.fail, r.pass, cyc + 1 + r.delay);
        @(negedge clk);
        start_s[r.g] = 1'b0;
        wait_drain(r.delay + 20);
        repeat (3) @(negedge clk);
        check("hold_err", 32'(err_w[r.g]), 32'(r.err));
        check("hold_fail", 32'(fail_w[r.g]), 32'(r.fail));
        check("hold_pass", 32'(pass_w[r.g]), 32'(r.pass));
    endtask

    // Cycle-by-cycle drive/busy/done timeline on instance 0 (settle 4, one loop).
    task automatic run_timeline(input bit pulse7);
        logic [1:0] e_drv;
        mode_s[0] = 0;
        @(negedge clk);
        start_s[0] = 1'b1;
        push_exp(0, 8'd0, 4'b0000, 1'b1, cyc + 21);
        @(posedge clk);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            start_s[0] = (pulse7 && c == 6);
            e_drv = (c < 20) ? 2'(c / 5) : 2'b00;
            check("tl_drv", 32'(drv_w[0]), 32'(e_drv));
            check("tl_busy", 32'(busy_w[0]), (c < 20) ? 32'd1 : 32'd0);
            check("tl_done", 32'(done_w[0]), (c == 20) ? 32'd1 : 32'd0);
        end
        wait_drain(5);
    endtask

    initial begin
        rows[0] = '{g: 0, mode: 0, err: 8'd0,  fail: 4'b0000, pass: 1'b1, delay: 20};
        rows[1] = '{g: 0, mode: 1, err: 8'd3,  fail: 4'b0111, pass: 1'b0, delay: 20};
        rows[2] = '{g: 0, mode: 4, err: 8'd3,  fail: 4'b1110, pass: 1'b0, delay: 20};
        rows[3] = '{g: 0, mode: 3, err: 8'd0,  fail: 4'b0000, pass: 1'b1, delay: 20};
        rows[4] = '{g: 1, mode: 2, err: 8'd16, fail: 4'b1111, pass: 1'b0, delay: 40};
        rows[5] = '{g: 1, mode: 5, err: 8'd8,  fail: 4'b1111, pass: 1'b0, delay: 40};
        rows[6] = '{g: 2, mode: 2, err: 8'd7,  fail: 4'b1111, pass: 1'b0, delay: 40};
        rows[7] = '{g: 2, mode: 1, err: 8'd6,  fail: 4'b0111, pass: 1'b0, delay: 40};
        rows[8] = '{g: 3, mode: 3, err: 8'd2,  fail: 4'b1010, pass: 1'b0, delay: 12};
        rows[9] = '{g: 3, mode: 0, err: 8'd0,  fail: 4'b0000, pass: 1'b1, delay: 12};

        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check("rst_drv", 32'(drv_w[g]), 32'd0);
            check("rst_busy", 32'(busy_w[g]), 32'd0);
            check("rst_done", 32'(done_w[g]), 32'd0);
            check("rst_pass", 32'(pass_w[g]), 32'd0);
            check("rst_err", 32'(err_w[g]), 32'd0);
            check("rst_fail", 32'(fail_w[g]), 32'd0);
        end
        rst_n_s = 4'b1111;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_row(rows[i]);

        run_timeline(1'b0);
        run_timeline(1'b1);

        // Reset at edge 12 of a failing run: everything clears with no done.
        mode_s[0] = 1;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (12) @(posedge clk);
        check("pre_rst_err", 32'(err_w[0]), 32'd2);
        #1 rst_n_s[0] = 1'b0;
        #1;
        check("arst_drv", 32'(drv_w[0]), 32'd0);
        check("arst_busy", 32'(busy_w[0]), 32'd0);
        check("arst_err", 32'(err_w[0]), 32'd0);
        check("arst_fail", 32'(fail_w[0]), 32'd0);
        check("arst_pass", 32'(pass_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n_s[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("aborted_err", 32'(err_w[0]), 32'd0);
        run_row('{g: 0, mode: 0, err: 8'd0, fail: 4'b0000, pass: 1'b1, delay: 20});

        // start held high on instance 3: second run starts two edges after DONE entry.
        mode_s[3] = 0;
        @(negedge clk);
        start_s[3] = 1'b1;
        push_exp(3, 8'd0, 4'b0000, 1'b1, cyc + 13);
        push_exp(3, 8'd0, 4'b0000, 1'b1, cyc + 27);
        repeat (15) @(negedge clk);
        start_s[3] = 1'b0;
        wait_drain(40);
        repeat (20) @(negedge clk);
        check("held_start_idle", 32'(busy_w[3]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
